perceptron_weight_update: RTL and testbench

//   Backward (learning) path of the single-layer perceptron. Consumes one weighted sum

---
 rtl/perceptron_weight_update.sv | 143 ++++++++++++++
 tb/tb_perceptron_weight_update.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_weight_update.sv
// Perceptron learning step: thresholds a weighted sum into a prediction and applies
// w_i += e*(x_i>>>SHIFT) one lane per cycle, returning the new weights over valid/ready.
module perceptron_weight_update #(
    parameter int N     = 3,
    parameter int SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [47:0]       sum,
    input  logic              target,
    input  logic [18*N-1:0]   x,
    input  logic [18*N-1:0]   w_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [18*N-1:0]   w_out,
    output logic              y,
    output logic              err,
    output logic [15:0]       err_cnt
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

    state_t            state, state_d;
    logic [47:0]       sum_r;
    logic              target_r;
    logic [18*N-1:0]   x_r;
    logic [18*N-1:0]   w_r;
    logic [18*N-1:0]   w_upd;
    logic [LW-1:0]     lane;
    logic              y_r;
    logic              e_neg;
    logic              accept;
    logic              last_lane;
    logic              y_c;
    logic              err_c;
    logic              in_ready_d;
    logic              out_valid_d;
    logic signed [17:0] x_k;
    logic signed [17:0] w_k;
    logic signed [17:0] xs_k;
    logic signed [18:0] delta;
    logic signed [18:0] acc;
    logic [17:0]       lane_new;

    assign accept    = (state == IDLE) && in_valid && in_ready;
    assign last_lane = (lane == LW'(N - 1));
    assign y_c       = ($signed(sum_r) > 48'sd0);
    assign err_c     = y_c ^ target_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
        state_d = state;
        case (state)
            IDLE:    if (accept)    state_d = CHECK;
            CHECK:   state_d = err_c ? UPDATE : DONE;
            UPDATE:  if (last_lane) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; handshake flags are registered from the next state
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // One-lane update datapath: 19-bit add, saturated back to 18 bits
    always_comb begin
        x_k   = $signed(x_r[18*int'(lane) +: 18]);
        w_k   = $signed(w_r[18*int'(lane) +: 18]);
        xs_k  = x_k >>> SHIFT;
        delta = e_neg ? -{xs_k[17], xs_k} : {xs_k[17], xs_k};
        acc   = {w_k[17], w_k} + delta;
        if (acc[18] != acc[17]) lane_new = acc[18] ? 18'h20000 : 18'h1FFFF;
        else                    lane_new = acc[17:0];
        w_upd = w_r;
        w_upd[18*int'(lane) +: 18] = lane_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum_r     <= '0;
            target_r  <= 1'b0;
            x_r       <= '0;
            w_r       <= '0;
            lane      <= '0;
            y_r       <= 1'b0;
            e_neg     <= 1'b0;
            w_out     <= '0;
            y         <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            case (state)
                IDLE: if (accept) begin
                    sum_r    <= sum;
                    target_r <= target;
                    x_r      <= x;
                    w_r      <= w_in;
                end
                CHECK: begin
                    y_r   <= y_c;
                    e_neg <= ~target_r;
                    lane  <= '0;
                    if (!err_c) begin
                        w_out <= w_r;
                        y     <= y_c;
                        err   <= 1'b0;
                    end
                end
                UPDATE: begin
                    w_r  <= w_upd;
                    lane <= lane + 1'b1;
                    if (last_lane) begin
                        w_out <= w_upd;
                        y     <= y_r;
                        err   <= 1'b1;
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Directed bench for perceptron_weight_update (N=3, SHIFT=2): vector table plus
// back-pressure and mid-update reset sequences.
module tb_perceptron_weight_update;

    localparam int N = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [47:0]     sum;
    logic            target;
    logic [18*N-1:0] x;
    logic [18*N-1:0] w_in;
    logic            out_valid;
    logic            out_ready;
    logic [18*N-1:0] w_out;
    logic            y;
    logic            err;
    logic [15:0]     err_cnt;

    perceptron_weight_update #(.N(N), .SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .target(target), .x(x), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .w_out(w_out),
        .y(y), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [53:0] x;
        logic [53:0] w;
        logic [47:0] sum;
        logic        target;
        logic        exp_y;
        logic        exp_err;
        logic [53:0] exp_w;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    function automatic logic [53:0] pack3(int l2, int l1, int l0);
        logic [17:0] a, b, c;
        a = 18'(l2);
        b = 18'(l1);
        c = 18'(l0);
        return {a, b, c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        x      = v.x;
        w_in   = v.w;
        sum    = v.sum;
        target = v.target;
    endtask

    // Hold in_valid until accepted; returns after the accepting edge (+1).
    task automatic send(input vec_t v, input string name);
        int n;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({name, "_accept_timeout"}, 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_ready_low"}, 64'(in_ready), 64'd0);
    endtask

    // Called #1 after the accepting edge; waits for out_valid and checks the result.
    task automatic wait_result(input vec_t v, input string name);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc + 1), 64'(v.exp_lat));
        check({name, "_w_out"}, 64'(w_out), 64'(v.exp_w));
        check({name, "_y"}, 64'(y), 64'(v.exp_y));
        check({name, "_err"}, 64'(err), 64'(v.exp_err));
        if (v.exp_err) exp_cnt++;
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_cnt));
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({name, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_w_out", 64'(w_out), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_y_err", 64'({y, err}), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_rise", 64'(in_ready), 64'd1);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        target    = 1'b0;
        x         = '0;
        w_in      = '0;
        rst_n     = 1'b1;

        vecs[0] = '{pack3(10, 10, 10), pack3(2, 500, 30), 48'd5320, 1'b1,
                    1'b1, 1'b0, pack3(2, 500, 30), 2};
        vecs[1] = '{pack3(10, 10, 10), pack3(2, 500, 30), 48'd5320, 1'b0,
                    1'b1, 1'b1, pack3(0, 498, 28), 5};
        vecs[2] = '{pack3(0, 0, 40), pack3(0, 0, 131070), -48'sd5, 1'b1,
                    1'b0, 1'b1, pack3(0, 0, 131071), 5};
        vecs[3] = '{pack3(0, 0, 40), pack3(0, 0, -131070), 48'd7, 1'b0,
                    1'b1, 1'b1, pack3(0, 0, -131072), 5};
        vecs[4] = '{pack3(10, 10, 10), pack3(2, 500, 30), 48'd0, 1'b1,
                    1'b0, 1'b1, pack3(4, 502, 32), 5};
        vecs[5] = '{pack3(10, 10, 10), pack3(2, 500, 30), 48'd0, 1'b0,
                    1'b0, 1'b0, pack3(2, 500, 30), 2};
        vecs[6] = '{pack3(-9, 100, -1), pack3(0, 0, 0), -48'sd1, 1'b1,
                    1'b0, 1'b1, pack3(-3, 25, -1), 5};
        vecs[7] = '{pack3(1, 2, 3), pack3(7, 8, 9), 48'h8000_0000_0000, 1'b0,
                    1'b0, 1'b0, pack3(7, 8, 9), 2};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            send(vecs[i], $sformatf("v%0d", i));
            wait_result(vecs[i], $sformatf("v%0d", i));
            handshake($sformatf("v%0d", i));
        end

        // Back-pressure: new sample waits while the previous result is unread
        begin
            logic [53:0] held;
            send(vecs[0], "bp_a");
            wait_result(vecs[0], "bp_a");
            held = w_out;
            drive(vecs[2]);
            in_valid = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("bp_hold_%0d", c), 64'(w_out), 64'(held));
                check($sformatf("bp_busy_%0d", c), 64'(in_ready), 64'd0);
            end
            handshake("bp_a");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_b_taken", 64'(in_ready), 64'd0);
            wait_result(vecs[2], "bp_b");
            handshake("bp_b");
        end

        // Reset in the middle of an update, then replay the same sample
        send(vecs[1], "mid");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_w_out", 64'(w_out), 64'd0);
        check("mid_err_cnt", 64'(err_cnt), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(vecs[1], "rerun");
        wait_result(vecs[1], "rerun");
        handshake("rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
